pes_graycode_seq: RTL and testbench
===================================

Name: pes_graycode_seq

Overview:
- Command-driven sequencer for the 8-bit parity-scheme Gray counter (`pes_graycode`).
- Drives the counter's `enable`/`reset` inputs and accepts CLEAR, STEP-n and RUN_TO-target commands over a valid/ready handshake.
- Keeps a shadow binary position so RUN_TO never overshoots, and reports completion with step count.
- Sits between the host/test logic and the counter instance.

Parameters:
- WIDTH, 8, Gray counter width; also the width of the command argument, position and step count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  opcode: 0 CLEAR, 1 STEP, 2 RUN_TO, 3 reserved (treated as STEP 0)
- cmd_arg  in  WIDTH  STEP: step count n; RUN_TO: target Gray value
- abort  in  1  stop the current STEP/RUN_TO early
- cnt_enable  out  1  to counter `enable`; registered
- cnt_reset  out  1  to counter `reset`
- gray_count  in  WIDTH  counter output, used only by the optional checker
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- aborted  out  1  valid with `done`: command ended by abort
- steps_taken  out  WIDTH  enables issued by the last command; valid from `done`, held until the next accept
- pos_gray  out  WIDTH  shadow Gray position, equal to pos ^ (pos>>1)

Behaviour:
- Reset: every output 0 except `cnt_reset` = 1. `cnt_reset` = `reset` OR registered clear pulse. Shadow pos = 0. FSM = IDLE.
- Reset mid-command: abandons the command immediately; no `done` is issued.
- FSM states are IDLE, CLEAR, RUN, DONE.
  - `cmd_ready` = (state == IDLE) && !reset.
  - Accept occurs on cmd_valid && cmd_ready at edge 0.
- CLEAR:
  - Cycle 1: `cnt_reset` = 1 and pos cleared at the end of the cycle.
  - Cycle 2: DONE, steps_taken = 0.
- STEP n:
  - remaining = n.
  - n > 0: RUN with `cnt_enable` = 1 for exactly n cycles (cycles 1..n); pos += 1 at each enable edge, modulo 2^WIDTH.
  - Then DONE in cycle n+1. Back to IDLE in cycle n+2.
  - n = 0: DONE in cycle 1.
- RUN_TO g:
  - At accept, tb = gray2bin(g) and n = (tb − pos) mod 2^WIDTH.
  - Then proceeds exactly as STEP n, so g == pos_gray gives n = 0.
  - Wrap-around is natural: target behind the current position takes the forward modular distance.
- DONE lasts one cycle: `done` = 1, `busy` = 0, `cmd_ready` = 0.
- `busy` = 1 in CLEAR and RUN.
- Abort:
  - Sampled in RUN; abort high at edge k stops further enables from cycle k+1.
  - DONE follows with aborted = 1 and steps_taken = enables actually issued.
  - Ignored in other states.
- Commands presented while not ready are held by the requester (valid stays high, argument stable). No queueing.
- Counter/shadow alignment: the counter and the shadow pos both update on the edge where registered `cnt_enable` is 1, so `gray_count` == pos_gray every cycle after reset.

Optional Feature:
- GRAY_CHECK_EN defined:
  - Adds output `seq_err` (1 bit, sticky), set when gray_count != pos_gray in any cycle with reset low.
  - Cleared by reset or a CLEAR command.
- Undefined: port absent, no comparator logic.

Decomposition:
- Package `pes_graycode_pkg`: opcode constants (OP_CLEAR, OP_STEP, OP_RUN_TO), FSM state encoding, and functions bin2gray and gray2bin parameterised on WIDTH.
- Sub-module: `pes_graycode_seq_core` (FSM + remaining/pos counters). The top wraps it with the optional checker. The counter itself is instantiated by the bench/system, not inside this block.

Test Plan:
- Reset then STEP 5 from pos 0 -> `cnt_enable` high 5 consecutive cycles, done with steps_taken = 5, pos_gray = gray_count = 0x07.
- RUN_TO 0x80 from pos 0 -> 255 enables, done, gray_count = 0x80, steps_taken = 0xFF; then RUN_TO 0x00 -> 1 enable (wrap), gray_count = 0x00.
- RUN_TO equal to current pos_gray, and STEP 0 -> done in cycle 1, zero enables, steps_taken = 0.
- STEP 20 with abort pulsed after the 7th enable cycle -> exactly 7 enables, done with aborted = 1, steps_taken = 7.
- STEP 10 then CLEAR -> `cnt_reset` pulse one cycle, gray_count = 0, pos_gray = 0; reset asserted mid-STEP -> `cnt_enable` 0 next cycle, no done, `cmd_ready` high after release.
- GRAY_CHECK_EN: force gray_count = 0x01 while pos_gray = 0x00 -> `seq_err` rises and stays high; CLEAR -> `seq_err` = 0.

Source files
------------

// File: rtl/pes_graycode_pkg.sv
// rtl/pes_graycode_pkg.sv - opcodes, sequencer states and Gray conversion helpers
package pes_graycode_pkg;

    // Helpers work on a fixed maximum width; callers zero-extend and truncate.
    localparam int GRAY_MAX_W = 32;

    localparam logic [1:0] OP_CLEAR  = 2'd0;
    localparam logic [1:0] OP_STEP   = 2'd1;
    localparam logic [1:0] OP_RUN_TO = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } seq_state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave the result unaffected.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/pes_graycode_seq_core.sv
// rtl/pes_graycode_seq_core.sv - command FSM with remaining-step and shadow position counters
module pes_graycode_seq_core
    import pes_graycode_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic             cnt_enable,
    output logic             clr_pulse,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] steps_taken,
    output logic [WIDTH-1:0] pos_gray
);

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] pos_q, pos_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    logic             abrt_q, abrt_d;
    logic             en_q, en_d;
    logic             clr_q, clr_d;
    logic             accept;
    logic [WIDTH-1:0] target_bin;
    logic [WIDTH-1:0] req_steps;

    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            pos_q   <= '0;
            steps_q <= '0;
            abrt_q  <= 1'b0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            pos_q   <= pos_d;
            steps_q <= steps_d;
            abrt_q  <= abrt_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
        end
    end

    // Next-state logic; RUN_TO becomes a forward modular step count at accept.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        pos_d      = pos_q;
        steps_d    = steps_q;
        abrt_d     = abrt_q;
        en_d       = 1'b0;
        clr_d      = 1'b0;
        target_bin = WIDTH'(gray2bin(GRAY_MAX_W'(cmd_arg)));
        req_steps  = '0;
        case (cmd_op)
            OP_STEP:   req_steps = cmd_arg;
            OP_RUN_TO: req_steps = target_bin - pos_q;
            default:   req_steps = '0;
        endcase
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    steps_d = '0;
                    abrt_d  = 1'b0;
                    if (cmd_op == OP_CLEAR) begin
                        state_d = S_CLEAR;
                        clr_d   = 1'b1;
                    end else if (req_steps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        rem_d   = req_steps;
                        en_d    = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                pos_d   = '0;
                state_d = S_DONE;
            end
            S_RUN: begin
                // The enable of this cycle is already committed to the counter.
                pos_d   = pos_q + WIDTH'(1);
                steps_d = steps_q + WIDTH'(1);
                rem_d   = rem_q - WIDTH'(1);
                if (abort || rem_q == WIDTH'(1)) begin
                    state_d = S_DONE;
                    abrt_d  = abort;
                end else begin
                    en_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cnt_enable  = en_q;
    assign clr_pulse   = clr_q;
    assign busy        = (state_q == S_CLEAR) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign aborted     = done && abrt_q;
    assign steps_taken = steps_q;
    assign pos_gray    = WIDTH'(bin2gray(GRAY_MAX_W'(pos_q)));

endmodule

// File: rtl/pes_graycode_seq.sv
// rtl/pes_graycode_seq.sv - Gray counter command sequencer top; GRAY_CHECK_EN adds sticky seq_err checker
module pes_graycode_seq
    import pes_graycode_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             abort,
    output logic             cnt_enable,
    output logic             cnt_reset,
    input  logic [WIDTH-1:0] gray_count,
`ifdef GRAY_CHECK_EN
    output logic             seq_err,
`endif
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] steps_taken,
    output logic [WIDTH-1:0] pos_gray
);

    logic clr_pulse;

    pes_graycode_seq_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .abort       (abort),
        .cnt_enable  (cnt_enable),
        .clr_pulse   (clr_pulse),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .steps_taken (steps_taken),
        .pos_gray    (pos_gray)
    );

    assign cnt_reset = reset || clr_pulse;

`ifdef GRAY_CHECK_EN
    logic seq_err_q;

    // Sticky divergence flag between the real counter and the shadow position.
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_err_q <= 1'b0;
        end else if (clr_pulse) begin
            seq_err_q <= 1'b0;
        end else if (gray_count != pos_gray) begin
            seq_err_q <= 1'b1;
        end
    end

    assign seq_err = seq_err_q;
`else
    logic unused_gray_count;
    assign unused_gray_count = ^gray_count;
`endif

endmodule

// File: tb/tb_pes_graycode_seq.sv
// tb/tb_pes_graycode_seq.sv - table, corner-case and randomized checks against a behavioural counter model
module tb_pes_graycode_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [W-1:0] cmd_arg = '0;
    logic         abort = 1'b0;
    logic         cnt_enable;
    logic         cnt_reset;
    logic [W-1:0] gray_count;
    logic         busy;
    logic         done;
    logic         aborted;
    logic [W-1:0] steps_taken;
    logic [W-1:0] pos_gray;
`ifdef GRAY_CHECK_EN
    logic         seq_err;
`endif

    logic [W-1:0] model_bin = '0;
    logic         force_en = 1'b0;
    logic [W-1:0] force_val = '0;

    int n_checks = 0;
    int n_errors = 0;
    int mpos;

    always #5 clk = ~clk;

    pes_graycode_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_arg     (cmd_arg),
        .abort       (abort),
        .cnt_enable  (cnt_enable),
        .cnt_reset   (cnt_reset),
        .gray_count  (gray_count),
`ifdef GRAY_CHECK_EN
        .seq_err     (seq_err),
`endif
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .steps_taken (steps_taken),
        .pos_gray    (pos_gray)
    );

    // Behavioural stand-in for the Gray counter: a binary count shown in Gray code.
    always @(posedge clk) begin
        if (cnt_reset) model_bin <= '0;
        else if (cnt_enable) model_bin <= model_bin + 8'd1;
    end
    assign gray_count = force_en ? force_val : (model_bin ^ (model_bin >> 1));

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 255;
    endfunction

    function automatic int from_gray(input int g);
        for (int b = 0; b < 256; b++) if (to_gray(b) == g) return b;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic exec(input string tag, input logic [1:0] op, input logic [7:0] arg,
                        input int abort_at, input int exp_en, input int exp_ab, input int exp_gray);
        int  waitc, n_en, first_en, last_en, n_busy, n_rst, done_cyc;
        bit  seen;
        waitc = 0;
        @(negedge clk);
        while (!cmd_ready && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, " ready"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_arg   = 8'($urandom);
        n_en = 0; first_en = 0; last_en = 0; n_busy = 0; n_rst = 0; done_cyc = 0; seen = 0;
        for (int c = 1; c <= 600 && !seen; c++) begin
            if (cnt_enable) begin
                n_en++;
                if (first_en == 0) first_en = c;
                last_en = c;
            end
            if (busy) n_busy++;
            if (cnt_reset) n_rst++;
            abort = (abort_at > 0) && cnt_enable && (n_en == abort_at);
            if (done) begin
                seen     = 1;
                done_cyc = c;
                chk({tag, " ready_in_done"}, int'(cmd_ready), 0);
                chk({tag, " aborted"}, int'(aborted), exp_ab);
                chk({tag, " steps_taken"}, int'(steps_taken), exp_en);
                chk({tag, " pos_gray"}, int'(pos_gray), exp_gray);
                chk({tag, " gray_count"}, int'(gray_count), exp_gray);
            end
            if (!seen) @(negedge clk);
        end
        abort = 1'b0;
        chk({tag, " done_seen"}, int'(seen), 1);
        chk({tag, " done_cycle"}, done_cyc, (op == 2'd0) ? 2 : exp_en + 1);
        chk({tag, " enables"}, n_en, exp_en);
        if (n_en > 0) chk({tag, " enables_contiguous"}, last_en - first_en + 1, n_en);
        if (n_en > 0) chk({tag, " first_enable_cycle"}, first_en, 1);
        chk({tag, " busy_cycles"}, n_busy, done_cyc - 1);
        chk({tag, " cnt_reset_cycles"}, n_rst, (op == 2'd0) ? 1 : 0);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        int         abort_at;
        int         exp_en;
        int         exp_ab;
        int         exp_gray;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int  n, op_sel, ab_at, en;
        logic [1:0] op;
        logic [7:0] arg;
        bit  done_seen;

        tbl[0]  = '{2'd1, 8'd5,    0, 5,   0, 8'h07};
        tbl[1]  = '{2'd0, 8'd0,    0, 0,   0, 8'h00};
        tbl[2]  = '{2'd2, 8'h80,   0, 255, 0, 8'h80};
        tbl[3]  = '{2'd2, 8'h00,   0, 1,   0, 8'h00};
        tbl[4]  = '{2'd2, 8'h00,   0, 0,   0, 8'h00};
        tbl[5]  = '{2'd1, 8'd0,    0, 0,   0, 8'h00};
        tbl[6]  = '{2'd3, 8'h33,   0, 0,   0, 8'h00};
        tbl[7]  = '{2'd1, 8'd20,   7, 7,   1, 8'h04};
        tbl[8]  = '{2'd1, 8'd10,   0, 10,  0, 8'h19};
        tbl[9]  = '{2'd0, 8'd0,    0, 0,   0, 8'h00};
        tbl[10] = '{2'd2, 8'h04,   0, 7,   0, 8'h04};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst cnt_reset", int'(cnt_reset), 1);
        chk("rst cnt_enable", int'(cnt_enable), 0);
        chk("rst cmd_ready", int'(cmd_ready), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst aborted", int'(aborted), 0);
        chk("rst steps_taken", int'(steps_taken), 0);
        chk("rst pos_gray", int'(pos_gray), 0);
`ifdef GRAY_CHECK_EN
        chk("rst seq_err", int'(seq_err), 0);
`endif
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst cnt_reset", int'(cnt_reset), 0);
        chk("post_rst cmd_ready", int'(cmd_ready), 1);

        foreach (tbl[i])
            exec($sformatf("vec%0d", i), tbl[i].op, tbl[i].arg, tbl[i].abort_at,
                 tbl[i].exp_en, tbl[i].exp_ab, tbl[i].exp_gray);

        // Reset asserted in the middle of a STEP
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 8'd50;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (cnt_enable) n++;
            if (n < 3) @(negedge clk);
        end
        chk("midrst enables_before", n, 3);
        reset = 1'b1;
        done_seen = 0;
        @(negedge clk);
        chk("midrst cnt_enable", int'(cnt_enable), 0);
        chk("midrst cnt_reset", int'(cnt_reset), 1);
        chk("midrst cmd_ready", int'(cmd_ready), 0);
        if (done) done_seen = 1;
        @(negedge clk);
        if (done) done_seen = 1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst ready_after", int'(cmd_ready), 1);
        chk("midrst pos_gray", int'(pos_gray), 0);
        chk("midrst gray_count", int'(gray_count), 0);
        chk("midrst steps_taken", int'(steps_taken), 0);
        repeat (3) begin
            if (done) done_seen = 1;
            @(negedge clk);
        end
        chk("midrst no_done", int'(done_seen), 0);

        // Randomized commands against the position model
        mpos = 0;
        for (int t = 0; t < 30; t++) begin
            op_sel = $urandom_range(0, 9);
            ab_at  = 0;
            if (op_sel == 0) begin
                op = 2'd0; arg = 8'($urandom); n = 0;
            end else if (op_sel <= 4) begin
                op = 2'd1; arg = 8'($urandom_range(0, 40)); n = arg;
            end else if (op_sel <= 8) begin
                op = 2'd2; arg = 8'($urandom);
                n = (from_gray(arg) - mpos + 256) % 256;
            end else begin
                op = 2'd3; arg = 8'($urandom); n = 0;
            end
            if (op != 2'd0 && n >= 2 && $urandom_range(0, 3) == 0) ab_at = $urandom_range(1, n - 1);
            en   = (ab_at > 0) ? ab_at : n;
            mpos = (op == 2'd0) ? 0 : (mpos + en) % 256;
            exec($sformatf("rnd%0d op%0d arg%0d", t, op, arg), op, arg, ab_at, en,
                 (ab_at > 0) ? 1 : 0, to_gray(mpos));
        end

`ifdef GRAY_CHECK_EN
        // Counter disagreeing with the shadow position
        exec("chk_clear0", 2'd0, 8'd0, 0, 0, 0, 0);
        @(negedge clk);
        chk("seq_err idle_clean", int'(seq_err), 0);
        force_val = 8'h01;
        force_en  = 1'b1;
        @(negedge clk);
        chk("seq_err rises", int'(seq_err), 1);
        force_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("seq_err sticky", int'(seq_err), 1);
        exec("chk_clear1", 2'd0, 8'd0, 0, 0, 0, 0);
        chk("seq_err cleared", int'(seq_err), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
